// File: rtl/rf_multiport.sv
// rtl/rf_multiport.sv - byte-enabled register file, two registered read ports, post-reset clear sweep
// Optional: define RF_ZERO_REG_EN to hardwire entry 0 to zero.
module rf_multiport #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wen,
    input  logic [AW-1:0]      wa,
    input  logic [WIDTH/8-1:0] wbe,
    input  logic [WIDTH-1:0]   din,
    input  logic [AW-1:0]      ra0,
    input  logic [AW-1:0]      ra1,
    output logic [WIDTH-1:0]   dout0,
    output logic [WIDTH-1:0]   dout1,
    output logic               busy,
    output logic               wr_err
);

    localparam int            NB      = WIDTH / 8;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     clr_ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    logic              wa_ok, ra0_ok, ra1_ok;
    logic              wr_acc, wr_rej;
    logic [WIDTH-1:0]  wr_word;
    logic [WIDTH-1:0]  rd0, rd1;

    always_comb begin
        state_nx = state;
        if (state == CLEAR && clr_ptr == LAST)
            state_nx = IDLE;
    end

    always_comb begin
        wa_ok  = {1'b0, wa}  < DEPTH_W;
        ra0_ok = {1'b0, ra0} < DEPTH_W;
        ra1_ok = {1'b0, ra1} < DEPTH_W;
`ifdef RF_ZERO_REG_EN
        // Entry 0 is constant zero: writes to it vanish without an error.
        ra0_ok = ra0_ok && (ra0 != '0);
        ra1_ok = ra1_ok && (ra1 != '0);
        wr_acc = (state == IDLE) && wen && wa_ok && (wa != '0);
`else
        wr_acc = (state == IDLE) && wen && wa_ok;
`endif
        wr_rej = wen && (busy || !wa_ok);

        wr_word = wa_ok ? mem[wa] : '0;
        for (int k = 0; k < NB; k++)
            if (wbe[k])
                wr_word[8*k +: 8] = din[8*k +: 8];

        // Write-first: an accepted write to the read address is forwarded merged.
        rd0 = '0;
        if (ra0_ok)
            rd0 = (wr_acc && wa == ra0) ? wr_word : mem[ra0];
        rd1 = '0;
        if (ra1_ok)
            rd1 = (wr_acc && wa == ra1) ? wr_word : mem[ra1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
            dout0   <= '0;
            dout1   <= '0;
            wr_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            busy    <= (state_nx == CLEAR);
            clr_ptr <= (state == CLEAR && clr_ptr != LAST) ? clr_ptr + 1'b1 : '0;
            dout0   <= (state == CLEAR) ? '0 : rd0;
            dout1   <= (state == CLEAR) ? '0 : rd1;
            wr_err  <= wr_rej;
        end
    end

    // The array has no reset; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_ptr] <= '0;
            else if (wr_acc)
                mem[wa] <= wr_word;
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// tb/tb_rf_multiport.sv - directed self-checking bench for rf_multiport
module tb_rf_multiport;

    logic        clk = 1'b0;
    logic        rst, wen;
    logic [3:0]  wa, ra0, ra1, wbe;
    logic [31:0] din, dout0, dout1;
    logic        busy, wr_err;

    logic        r_rst, r_wen;
    logic [3:0]  r_wa, r_ra0, r_ra1, r_wbe;
    logic [31:0] r_din, r_dout0, r_dout1;
    logic        r_busy, r_err;

    int tests  = 0;
    int failed = 0;
    int n;

    always #5 clk = ~clk;

    rf_multiport dut (
        .clk(clk), .rst(rst), .wen(wen), .wa(wa), .wbe(wbe), .din(din),
        .ra0(ra0), .ra1(ra1), .dout0(dout0), .dout1(dout1),
        .busy(busy), .wr_err(wr_err)
    );

    rf_multiport #(.WIDTH(32), .DEPTH(12), .AW(4)) u12 (
        .clk(clk), .rst(r_rst), .wen(r_wen), .wa(r_wa), .wbe(r_wbe), .din(r_din),
        .ra0(r_ra0), .ra1(r_ra1), .dout0(r_dout0), .dout1(r_dout1),
        .busy(r_busy), .wr_err(r_err)
    );

    typedef struct {
        logic        wen;
        logic [3:0]  wa;
        logic [3:0]  wbe;
        logic [31:0] din;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

`ifdef RF_ZERO_REG_EN
    localparam logic [31:0] Z0 = 32'h0000_0000;
`else
    localparam logic [31:0] Z0 = 32'h1234_5678;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (busy && cnt < 200);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'd3,  4'b1111, 32'hAABBCCDD, 4'd3,  4'd4,  32'hAABBCCDD, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 4'd3,  4'b0101, 32'h11223344, 4'd3,  4'd3,  32'hAA22CC44, 32'hAA22CC44, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  4'b0000, 32'h0,        4'd3,  4'd0,  32'hAA22CC44, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 4'd5,  4'b1111, 32'hDEADBEEF, 4'd5,  4'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b0, 4'd0,  4'b0000, 32'h0,        4'd5,  4'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[5]  = '{1'b1, 4'd5,  4'b0000, 32'h0,        4'd5,  4'd3,  32'hDEADBEEF, 32'hAA22CC44, 1'b0};
        vecs[6]  = '{1'b1, 4'd15, 4'b1000, 32'h77000000, 4'd15, 4'd5,  32'h77000000, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 4'd5,  4'b0010, 32'h00001200, 4'd3,  4'd5,  32'hAA22CC44, 32'hDEAD12EF, 1'b0};
        vecs[8]  = '{1'b0, 4'd0,  4'b0000, 32'h0,        4'd15, 4'd15, 32'h77000000, 32'h77000000, 1'b0};
        vecs[9]  = '{1'b1, 4'd0,  4'b1111, 32'h12345678, 4'd0,  4'd0,  Z0,           Z0,           1'b0};
        vecs[10] = '{1'b0, 4'd0,  4'b0000, 32'h0,        4'd0,  4'd7,  Z0,           32'h0,        1'b0};

        rst = 1'b1; wen = 1'b1; wa = 4'd2; wbe = 4'hF; din = 32'h0; ra0 = 4'd0; ra1 = 4'd0;
        r_rst = 1'b1; r_wen = 1'b0; r_wa = '0; r_wbe = '0; r_din = '0; r_ra0 = '0; r_ra1 = '0;
        step();
        step();
        chk("reset_busy",   32'(busy),   32'd1);
        chk("reset_dout0",  dout0,       32'h0);
        chk("reset_dout1",  dout1,       32'h0);
        chk("reset_wr_err", 32'(wr_err), 32'd0);
        wen = 1'b0;

        rst = 1'b0;
        count_busy(n);
        chk("first_sweep_len", n, 16);

        for (int i = 0; i < 16; i++) begin
            wen = 1'b1; wa = 4'(i); din = 32'hFFFF_FFFF; wbe = 4'hF;
            step();
        end
        wen = 1'b0; ra0 = 4'd7;
        step();
        chk("preload_rd", dout0, 32'hFFFF_FFFF);

        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(n);
        chk("clear_sweep_len", n, 16);
        for (int i = 0; i < 16; i++) begin
            ra0 = 4'(i); ra1 = 4'(15 - i);
            step();
            chk($sformatf("cleared0_%0d", i), dout0, 32'h0);
            chk($sformatf("cleared1_%0d", i), dout1, 32'h0);
        end

        foreach (vecs[i]) begin
            wen = vecs[i].wen; wa = vecs[i].wa; wbe = vecs[i].wbe; din = vecs[i].din;
            ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
            step();
            chk($sformatf("vec%0d_dout0", i),  dout0,       vecs[i].exp0);
            chk($sformatf("vec%0d_dout1", i),  dout1,       vecs[i].exp1);
            chk($sformatf("vec%0d_wr_err", i), 32'(wr_err), 32'(vecs[i].exp_err));
        end
        wen = 1'b0;

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        do begin
            if (n == 2) begin
                wen = 1'b1; wa = 4'd1; din = 32'h5555_5555; wbe = 4'hF;
            end else begin
                wen = 1'b0;
            end
            step();
            n++;
            if (n == 3) chk("busy_wr_err",       32'(wr_err), 32'd1);
            if (n == 4) chk("busy_wr_err_pulse", 32'(wr_err), 32'd0);
        end while (busy && n < 200);
        chk("restart_sweep_len", n, 16);
        ra0 = 4'd1;
        step();
        chk("busy_write_dropped", dout0, 32'h0);

        r_rst = 1'b1;
        step();
        r_rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (r_busy && n < 200);
        chk("d12_sweep_len", n, 12);
        r_wen = 1'b1; r_wa = 4'd13; r_din = 32'hFFFF_FFFF; r_wbe = 4'hF; r_ra1 = 4'd14;
        step();
        chk("d12_oor_wr_err", 32'(r_err), 32'd1);
        chk("d12_oor_read",   r_dout1,    32'h0);
        r_wen = 1'b0;
        step();
        chk("d12_wr_err_pulse", 32'(r_err), 32'd0);
        for (int i = 0; i < 12; i++) begin
            r_ra0 = 4'(i);
            step();
            chk($sformatf("d12_unchanged_%0d", i), r_dout0, 32'h0);
        end
        r_wen = 1'b1; r_wa = 4'd11; r_din = 32'hCAFE_F00D; r_ra0 = 4'd11;
        step();
        chk("d12_last_bypass", r_dout0, 32'hCAFE_F00D);
        chk("d12_last_no_err", 32'(r_err), 32'd0);
        r_wen = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
Parametrised register file: byte-enabled write port, two registered read ports with write-first bypass, and a hardware clear sweep after reset.
- Next generation of the 16x32 single-read-port register file used in the router datapath.
- Serves as per-port descriptor and state storage for the router.
- Guarantees every entry reads zero after reset, which the earlier block did not.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8
DEPTH, 16, number of entries; need not be a power of two
AW, 4, address width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
wen  input  1  write enable
wa  input  AW  write address
wbe  input  WIDTH/8  byte write enables; bit k covers din[8k+7:8k]
din  input  WIDTH  write data
ra0  input  AW  read address, port 0
ra1  input  AW  read address, port 1
dout0  output  WIDTH  registered read data, port 0
dout1  output  WIDTH  registered read data, port 1
busy  output  1  high while the clear sweep is running; writes ignored
wr_err  output  1  one-cycle pulse: write rejected (out of range or busy)

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high. Only state, pointer and outputs are reset; the array itself is cleared by the sweep.
- Reset values, while rst is high: state=CLEAR, clr_ptr=0, busy=1, dout0=dout1=0, wr_err=0. No array writes occur.
- FSM has two states, CLEAR and IDLE.
- CLEAR state:
  - Each cycle with rst low, write all-zero to entry clr_ptr, then clr_ptr+1.
  - On the cycle that writes entry DEPTH-1, next state is IDLE.
  - busy is registered: it drops exactly DEPTH cycles after the first rising edge with rst low.
- rst during CLEAR (mid-sweep): the sweep restarts at entry 0, with the full DEPTH cycles again.
- rst in IDLE: returns to CLEAR; all entries are re-cleared.
- Reads during CLEAR: dout0 and dout1 are forced to 0.
- Write, in IDLE only:
  - Condition: wen=1, wa<DEPTH, and the rising edge.
  - Byte k of r[wa] takes din byte k where wbe[k]=1; other bytes are unchanged.
  - wen=1 with wbe=0 is a legal no-op, with no wr_err.
- Write rejection:
  - wen=1 and wa>=DEPTH: no array change; wr_err=1 on the next cycle.
  - wen=1 while busy=1: same response, no array change and wr_err=1 on the next cycle.
  - wr_err is a one-cycle pulse per rejected request.
- Read latency is 1 cycle: dout0 in cycle n+1 shows r[ra0] as sampled in cycle n. Port 1 behaves identically and independently.
- Read address out of range: raX>=DEPTH returns 0 on that port.
- Write-first bypass: if in cycle n an accepted write has wa==raX, then doutX in cycle n+1 shows the merged word:
  - new din bytes where wbe=1;
  - old stored bytes elsewhere.
- Both read ports may name the same address, including the write address. Both then return the same value.
- Outputs hold their last value only as long as raX is stable and there is no write. There is no separate read enable; doutX updates every cycle.

Optional Feature:
Macro RF_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired zero.
  - Writes to wa=0 are silently dropped, with no wr_err.
  - Reads of address 0 return 0, including via bypass.
  - The sweep still runs for DEPTH cycles.
- Undefined: entry 0 is an ordinary register.

Test Plan:
- Reset/clear: preload all entries with 0xFFFFFFFF, pulse rst for 1 cycle → busy=1 for exactly 16 cycles; then reading all 16 addresses on both ports returns 0x00000000.
- Byte write: write wa=3, din=0xAABBCCDD, wbe=4'b1111; then din=0x11223344, wbe=4'b0101 → next-cycle read of ra0=3 returns 0xAA22CC44.
- Bypass: in one cycle, wen=1, wa=5, din=0xDEADBEEF, wbe=4'b1111, ra0=5, ra1=5 → both douts=0xDEADBEEF on the next cycle. Reading without a write in the following cycle returns the same value.
- Mid-sweep reset: assert rst again 7 cycles into the sweep → busy stays 1 for 16 more cycles. A write attempted at cycle 3 of the new sweep gives wr_err=1 and is not stored.
- Out-of-range: DEPTH=12, AW=4, write wa=13 → wr_err=1 for one cycle, no entry changed; read ra1=14 returns 0.
- Zero register with RF_ZERO_REG_EN: write wa=0, din=0x12345678 → wr_err=0; read ra0=0 returns 0 with and without the same-cycle bypass. Without the macro, the same sequence returns 0x12345678.
